// File: rtl/lfsr_match_monitor_if.sv
// rtl/lfsr_match_monitor_if.sv - counter observation, target handshake and status bundle
interface lfsr_match_monitor_if #(
  parameter int WIDTH  = 64,
  parameter int STEP_W = 32,
  parameter int CNT_W  = 16
);
  logic              count;
  logic [WIDTH-1:0]  q;
  logic              tgt_valid;
  logic [WIDTH-1:0]  tgt_data;
  logic              tgt_ready;
  logic              clr;
  logic              match;
  logic              timeout;
  logic [STEP_W-1:0] hit_steps;
  logic [CNT_W-1:0]  match_cnt;
  logic              lockup;

  modport master (
    output count, q, tgt_valid, tgt_data, clr,
    input  tgt_ready, match, timeout, hit_steps, match_cnt, lockup
  );

  modport slave (
    input  count, q, tgt_valid, tgt_data, clr,
    output tgt_ready, match, timeout, hit_steps, match_cnt, lockup
  );
endinterface

// File: rtl/lfsr_match_monitor.sv
// rtl/lfsr_match_monitor.sv - watches an LFSR state word for an armed target, with timeout and lock-up flag
module lfsr_match_monitor #(
  parameter int WIDTH         = 64,
  parameter int STEP_W        = 32,
  parameter int CNT_W         = 16,
  parameter int TIMEOUT_STEPS = 1000
) (
  input  logic clk,
  input  logic rst,
  lfsr_match_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, HIT, TMO} state_t;

  localparam logic [STEP_W-1:0] TMO_LIMIT = STEP_W'(TIMEOUT_STEPS);

  state_t            state;
  logic [WIDTH-1:0]  tgt;
  logic [STEP_W-1:0] steps;
  logic [STEP_W-1:0] hit_steps;
  logic [CNT_W-1:0]  match_cnt;
  logic              match;
  logic              timeout;
  logic              lockup;
  logic              z_prev;
  logic              z_now;
  logic              hit;

  assign z_now = (bus.q == '0) && bus.count;
  assign hit   = (state == ARMED) && (bus.q == tgt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tgt       <= '0;
      steps     <= '0;
      hit_steps <= '0;
      match_cnt <= '0;
      match     <= 1'b0;
      timeout   <= 1'b0;
      lockup    <= 1'b0;
      z_prev    <= 1'b0;
    end else begin
      match   <= 1'b0;
      timeout <= 1'b0;
      z_prev  <= z_now;
      case (state)
        IDLE: begin
          if (bus.tgt_valid) begin
            tgt   <= bus.tgt_data;
            steps <= '0;
            state <= ARMED;
          end
        end
        ARMED: begin
          // A hit wins over both the advance and the expiry check.
          if (hit) begin
            hit_steps <= steps;
            match     <= 1'b1;
            state     <= HIT;
          end else if (bus.count) begin
            if (steps != '1) steps <= steps + STEP_W'(1);
          end else if (steps == TMO_LIMIT) begin
            timeout <= 1'b1;
            state   <= TMO;
          end
        end
        HIT:     state <= IDLE;
        TMO:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (bus.clr) begin
        match_cnt <= '0;
        lockup    <= 1'b0;
      end else begin
        if (hit && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
        if (z_prev && z_now) lockup <= 1'b1;
      end
    end
  end

  assign bus.tgt_ready = (state == IDLE);
  assign bus.match     = match;
  assign bus.timeout   = timeout;
  assign bus.hit_steps = hit_steps;
  assign bus.match_cnt = match_cnt;
  assign bus.lockup    = lockup;
endmodule

// File: tb/tb_lfsr_match_monitor.sv
// tb/tb_lfsr_match_monitor.sv - scoreboard bench for lfsr_match_monitor
module tb_lfsr_match_monitor;
  localparam int WIDTH  = 64;
  localparam int STEP_W = 32;
  localparam int CNT_W  = 4;

  typedef struct {
    bit          is_match;
    int          cyc;
    logic [31:0] steps;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  lfsr_match_monitor_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut_if ();

  lfsr_match_monitor #(
    .WIDTH(WIDTH), .STEP_W(STEP_W), .CNT_W(CNT_W), .TIMEOUT_STEPS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dut_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [63:0] d);
    dut_if.tgt_valid = 1'b1;
    dut_if.tgt_data  = d;
    chk("arm_ready", 64'(dut_if.tgt_ready), 64'd1);
    tick();
    dut_if.tgt_valid = 1'b0;
  endtask

  task automatic expect_pulse(input bit is_match, input logic [31:0] steps, input logic [3:0] cnt);
    exp_t e;
    e.is_match = is_match;
    e.cyc      = cyc + 1;
    e.steps    = steps;
    e.cnt      = cnt;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must be matched by the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (dut_if.match || dut_if.timeout)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {62'b0, dut_if.match, dut_if.timeout}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_match", 64'(dut_if.match), 64'(e.is_match));
        chk("pulse_timeout", 64'(dut_if.timeout), 64'(!e.is_match));
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("hit_steps", 64'(dut_if.hit_steps), 64'(e.steps));
        chk("match_cnt", 64'(dut_if.match_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dut_if.count     = 1'b0;
    dut_if.q         = 64'h77;
    dut_if.tgt_valid = 1'b0;
    dut_if.tgt_data  = '0;
    dut_if.clr       = 1'b0;
    rst              = 1'b1;
    tick();
    tick();
    chk("rst_ready", 64'(dut_if.tgt_ready), 64'd1);
    chk("rst_match", 64'(dut_if.match), 64'd0);
    chk("rst_timeout", 64'(dut_if.timeout), 64'd0);
    chk("rst_hit_steps", 64'(dut_if.hit_steps), 64'd0);
    chk("rst_match_cnt", 64'(dut_if.match_cnt), 64'd0);
    chk("rst_lockup", 64'(dut_if.lockup), 64'd0);
    rst = 1'b0;
    repeat (3) tick();

    // basic hit: target 3 reached after two advances
    arm(64'h3);
    dut_if.count = 1'b1;
    dut_if.q = 64'h1; tick();
    dut_if.q = 64'h2; tick();
    dut_if.q = 64'h3;
    expect_pulse(1'b1, 32'd2, 4'd1);
    tick();
    dut_if.q = 64'h77; dut_if.count = 1'b0;
    chk("hit_not_ready", 64'(dut_if.tgt_ready), 64'd0);
    tick();
    chk("hit_ready_back", 64'(dut_if.tgt_ready), 64'd1);
    tick();

    // timeout after 8 non-matching advances
    arm(64'hDEAD);
    for (int i = 0; i < 8; i++) begin
      dut_if.q = 64'(100 + i); dut_if.count = 1'b1; tick();
    end
    dut_if.count = 1'b0; dut_if.q = 64'h77;
    expect_pulse(1'b0, 32'd2, 4'd1);
    repeat (3) tick();
    chk("tmo_ready_back", 64'(dut_if.tgt_ready), 64'd1);
    tick();

    // target appears on the 8th advance: match wins
    arm(64'hDEAD);
    for (int i = 0; i < 7; i++) begin
      dut_if.q = 64'(200 + i); dut_if.count = 1'b1; tick();
    end
    dut_if.q = 64'hDEAD;
    expect_pulse(1'b1, 32'd7, 4'd2);
    tick();
    dut_if.count = 1'b0; dut_if.q = 64'h77;
    repeat (3) tick();

    // new offer while armed is ignored
    arm(64'h55);
    dut_if.tgt_valid = 1'b1; dut_if.tgt_data = 64'h66; dut_if.q = 64'h66;
    chk("armed_not_ready", 64'(dut_if.tgt_ready), 64'd0);
    repeat (3) tick();
    dut_if.q = 64'h55;
    expect_pulse(1'b1, 32'd0, 4'd3);
    tick();
    dut_if.tgt_valid = 1'b0; dut_if.q = 64'h77;
    repeat (3) tick();

    // lock-up: single zero sample, then two consecutive
    dut_if.q = 64'h0; dut_if.count = 1'b1; tick();
    dut_if.q = 64'h77; dut_if.count = 1'b0; tick(); tick();
    chk("lockup_single", 64'(dut_if.lockup), 64'd0);
    dut_if.q = 64'h0; dut_if.count = 1'b1; tick(); tick();
    dut_if.q = 64'h77; dut_if.count = 1'b0;
    chk("lockup_set", 64'(dut_if.lockup), 64'd1);
    repeat (3) tick();
    chk("lockup_sticky", 64'(dut_if.lockup), 64'd1);
    dut_if.clr = 1'b1; tick();
    dut_if.clr = 1'b0;
    chk("clr_lockup", 64'(dut_if.lockup), 64'd0);
    chk("clr_match_cnt", 64'(dut_if.match_cnt), 64'd0);

    // saturation of the match counter
    dut_if.q = 64'h9;
    for (int k = 1; k <= 17; k++) begin
      arm(64'h9);
      expect_pulse(1'b1, 32'd0, (k > 15) ? 4'd15 : 4'(k));
      tick();
      tick();
    end
    dut_if.q = 64'h77;
    tick();
    chk("sat_match_cnt", 64'(dut_if.match_cnt), 64'd15);

    // reset while armed discards the target
    arm(64'h5);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(dut_if.tgt_ready), 64'd1);
    chk("midrst_match_cnt", 64'(dut_if.match_cnt), 64'd0);
    tick();
    rst = 1'b0;
    dut_if.q = 64'h5;
    repeat (4) tick();
    chk("midrst_ready_after", 64'(dut_if.tgt_ready), 64'd1);
    chk("midrst_hit_steps", 64'(dut_if.hit_steps), 64'd0);

    repeat (2) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lfsr_match_monitor.md
# lfsr_match_monitor

Downstream observer for the 64-bit Galois LFSR counter. It watches the counter's state word `q` and its `count` enable, accepts a target state through a valid/ready handshake, and pulses `match` when the counter reaches that state. It also reports how many counter advances the match took, times out if the target never appears, counts matches, and flags LFSR lock-up (all-zero state while counting).

## Interface

Parameters:
- `WIDTH`, 64: LFSR state width.
- `STEP_W`, 32: width of the step counter and of `hit_steps`.
- `CNT_W`, 16: width of `match_cnt`.
- `TIMEOUT_STEPS`, 1000: advances allowed after arming before `timeout`. Must be ≥1 and < 2^STEP_W.

Ports:
- `clk`, in, 1: single clock; all state on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `count`, in, 1: LFSR advance enable, the same signal that drives the counter.
- `q`, in, WIDTH: current LFSR state (counter output `Q`).
- `tgt_valid`, in, 1: target offer.
- `tgt_data`, in, WIDTH: target state.
- `tgt_ready`, out, 1: high only in IDLE.
- `clr`, in, 1: synchronous clear of `match_cnt` and `lockup`.
- `match`, out, 1: one-cycle pulse on a target hit.
- `timeout`, out, 1: one-cycle pulse when the arm expires.
- `hit_steps`, out, STEP_W: step count latched at the last match.
- `match_cnt`, out, CNT_W: saturating total of matches.
- `lockup`, out, 1: sticky lock-up flag.

## Operation

- **Reset (async):**
  - State goes to IDLE; target register = 0; step counter = 0.
  - `match`=0, `timeout`=0, `hit_steps`=0, `match_cnt`=0, `lockup`=0.
  - `tgt_ready`=1, since the block is in IDLE.
- **States:** IDLE, ARMED, HIT, TMO.
- **IDLE:**
  - `tgt_ready`=1.
  - On `tgt_valid`&`tgt_ready`: capture `tgt_data`, clear the step counter, go to ARMED.
- **ARMED:**
  - `tgt_ready`=0; `tgt_valid` is ignored.
  - Each cycle, `eq` = (`q` == target).
  - If `eq`: latch the step counter into `hit_steps` and go to HIT. The step counter does not increment that cycle.
  - Else, if `count`=1: increment the step counter.
  - Else, if the step counter == `TIMEOUT_STEPS`: go to TMO. This check uses the pre-increment value, so the timeout cycle comes after the last allowed advance.
- **HIT:**
  - `match`=1 for this one cycle.
  - `match_cnt` += 1, saturating at 2^CNT_W−1.
  - Next state is IDLE.
- **TMO:**
  - `timeout`=1 for this one cycle.
  - `hit_steps` is unchanged.
  - Next state is IDLE.
- **Priority in ARMED:** `eq` beats timeout. A match in the same cycle the timeout condition holds goes to HIT, and `timeout` never asserts.
- **Lock-up detection (all states):**
  - `z_prev` registers (`q`==0 && `count`).
  - If `z_prev` && `q`==0 && `count`, set `lockup`=1. It is sticky.
  - A single zero sample does not set it.
- **clr:**
  - Zeros `match_cnt` and `lockup` on the next edge.
  - Has priority over a same-cycle increment or set.
  - Does not affect the FSM, the target or `hit_steps`.
- **Width rules:**
  - The step counter saturates at 2^STEP_W−1. This is unreachable with a legal `TIMEOUT_STEPS`.
  - The comparison is the full WIDTH bits, unsigned equality.
- **Target = 0:** legal, and matches only if `q` is 0 while ARMED.

## Timing

- Handshake accepted at edge t: ARMED from cycle t+1, and the comparison is live from t+1.
- `eq` true in cycle c:
  - `match` is high in cycle c+1 (HIT).
  - IDLE and `tgt_ready`=1 from c+2.
  - The earliest re-arm is accepted at edge c+2.
- Timeout detected in cycle c: `timeout` high in c+1, `tgt_ready`=1 from c+2.
- `hit_steps` and `match_cnt` update at the edge that enters HIT, so they are visible together with `match`.
- `lockup` rises one cycle after the second consecutive counting zero sample.
- All outputs are registered. There are no combinational paths from input to output except `tgt_ready`, which decodes the state only.
- `rst` mid-operation in any state: immediate return to reset values. The armed target is discarded.

## Test plan

- **Reset:**
  - Stimulus: hold `rst`=1 for 2 cycles, then release.
  - Required: all outputs 0 except `tgt_ready`=1. After release, no pulses with `tgt_valid`=0.
- **Basic hit:**
  - Stimulus: arm with `tgt_data`=64'h3, then drive `q`=1,2,3 on consecutive cycles with `count`=1.
  - Required: `match`=1 exactly one cycle after the `q`=3 cycle; `hit_steps`=2; `match_cnt`=1; `tgt_ready` back to 1 two cycles after `q`=3.
- **Timeout:**
  - Stimulus: `TIMEOUT_STEPS`=8, arm with 64'hDEAD, apply 8 non-matching `count` cycles, then hold `count`=0.
  - Required: `timeout` pulses once; no `match`; `hit_steps` unchanged.
  - Follow-up: in the 8th-count cycle, drive `q`=64'hDEAD instead. Required: `match` only, and `hit_steps`=7.
- **Lock-up:**
  - Stimulus: `q`=0 with `count`=1 for 1 cycle. Required: `lockup`=0.
  - Stimulus: `q`=0 with `count`=1 for 2 consecutive cycles. Required: `lockup`=1 and stays 1.
  - Stimulus: `clr` for 1 cycle. Required: `lockup`=0 and `match_cnt`=0.
- **Handshake and saturation:**
  - Stimulus: hold `tgt_valid` during ARMED with a new value.
  - Required: ignored; the original target still matches.
  - Stimulus: force 2^CNT_W matches. Required: `match_cnt` stays at 16'hFFFF.
- **Reset mid-arm:**
  - Stimulus: assert `rst` while ARMED with target 64'h5, release, then drive `q`=5 without re-arming.
  - Required: no `match`; `tgt_ready`=1.
